stepper_phase_sequencer: RTL
============================

// Module: stepper_phase_sequencer
// PURPOSE
//  Consumes the slow divided step clock and drives the 4 coil lines of a unipolar/bipolar stepper.
//  Runs move commands (direction + step count) through a ready/valid handshake.
//  Tracks absolute position, holds the coils energised after each move, then releases them.
//  Sits between the step-rate clock divider (upstream) and the motor driver pins (downstream).
// PARAMETERS
//  HALF_STEP   0    0: 4-entry two-phase full-step table; 1: 8-entry half-step table
//  HOLD_STEPS  16   step_clk rising edges to keep coils energised after a move; 0 = hold forever
//  STEP_W      16   width of cmd_steps and the remaining-step counter
//  POS_W       32   width of the signed position counter
// PORTS
//  clk          in   1       system clock; same domain as step_clk
//  reset_reset  in   1       synchronous reset, active-high
//  step_clk     in   1       divided step clock (level); each rising edge = one step opportunity
//  cmd_valid    in   1       move command valid
//  cmd_ready    out  1       sequencer can accept a command
//  cmd_dir      in   1       1 = forward (phase +1, position +1); 0 = reverse
//  cmd_steps    in   STEP_W  number of steps to take
//  abort        in   1       stop current move immediately
//  coil         out  4       coil drive {A,B,C,D}; 0000 = released
//  busy         out  1       high in RUN
//  done         out  1       1-cycle pulse when a move finishes or is aborted
//  aborted      out  1       qualifies done: 1 = move ended by abort
//  position     out  POS_W   signed absolute step count
// BEHAVIOUR
//  Reset (reset_reset=1 at clk edge): state IDLE, phase idx 0, remaining 0, position 0, coil 0000,
//   busy 0, done 0, aborted 0, step_q 0. cmd_ready is 0 while reset_reset is high.
//  Edge detect: step_q <= step_clk each clk; edge = step_clk & ~step_q (no synchroniser; same domain).
//  Tables, index 0 first. Full: 1100,0110,0011,1001. Half: 1000,1100,0100,0110,0010,0011,0001,1001.
//   Index wraps modulo table length in both directions.
//  cmd_ready = ~reset_reset & (state != RUN) (combinational). Accept = cmd_valid & cmd_ready.
//  States:
//   IDLE: coil 0000. Accept with steps>0 -> RUN; remaining<=cmd_steps, dir latched.
//   RUN:  coil = table[idx], registered. On edge: idx+/-1, position+/-1, remaining-1.
//         Step taking remaining to 0 -> HOLD; done=1, aborted=0 on the following cycle.
//         abort=1 -> HOLD next clk; remaining<=0; done=1, aborted=1. Abort beats a coincident edge
//         (no step, no position change).
//   HOLD: coil = table[idx]; hold counter cleared on entry, +1 per edge.
//         Counter reaching HOLD_STEPS (HOLD_STEPS!=0) -> IDLE, coil 0000 next cycle.
//         abort=1 in HOLD -> IDLE (release). Accept with steps>0 -> RUN.
//  Zero-step command (accepted, cmd_steps=0): no motion; -> HOLD (counter cleared), coil = table[idx],
//   done=1, aborted=0 one cycle after accept.
//  Accept cycle coinciding with an edge: that edge is not used. First step is the next edge.
//  Edge latency: edge at clk N -> coil/position updated visible after clk N (one-cycle register).
//  abort in IDLE: ignored. Accept and abort in the same cycle: abort ignored, command accepted.
//  position wraps two's-complement at POS_W; idx is retained across moves (no realignment).
//  Mid-operation reset: everything returns to reset values at that edge. No done is produced.
//  done and aborted are 0 except for the single done cycle.
// TESTING
//  Reset, then cmd dir=1 steps=5, HALF_STEP=0 -> coil 1100,0110,0011,1001,1100 then 0110
//   (5 edges), position=5, one done pulse, aborted=0.
//  HALF_STEP=1, dir=0, steps=3 from idx 0 -> coil 1001,0001,0011; position=-3.
//  HOLD_STEPS=2: after move completes, coil stays energised 2 edges, then 0000, cmd_ready stays 1.
//  abort on same clk as 3rd edge of a 10-step move -> position=2, done=1 & aborted=1, state HOLD.
//  cmd_steps=0 in IDLE -> no position change, done one cycle later, coil=table[idx].
//  cmd_valid held during RUN -> cmd_ready=0, no accept; reset mid-move -> coil 0000, position 0.

Source files
------------

// File: rtl/stepper_phase_sequencer_if.sv
// Move-command channel for the stepper phase sequencer.
// The master issues direction/step-count commands and abort; the slave reports ready.
interface stepper_phase_sequencer_if #(
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        input  abort,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_phase_sequencer.sv
// Stepper coil sequencer: runs move commands on divided step-clock edges,
// tracks absolute position, holds coils after a move, then releases them.
module stepper_phase_sequencer #(
    parameter bit          HALF_STEP  = 1'b0,
    parameter int unsigned HOLD_STEPS = 16,
    parameter int          STEP_W     = 16,
    parameter int          POS_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset_reset,
    input  logic                   step_clk,
    stepper_phase_sequencer_if.slave cmd,
    output logic [3:0]             coil,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic signed [POS_W-1:0] position
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0]  IDX_MASK = HALF_STEP ? 3'd7 : 3'd3;
    localparam logic [31:0] HOLD_LIM = 32'(HOLD_STEPS);

    state_t            state;
    logic [2:0]        idx;
    logic [STEP_W-1:0] remaining;
    logic [31:0]       hold_cnt;
    logic              dir;
    logic              step_q;

    logic       edge_det;
    logic       accept;
    logic [2:0] idx_step;
    logic [31:0] hold_inc;

    function automatic logic [3:0] phase_of(input logic [2:0] i);
        logic [3:0] p;
        p = 4'b0000;
        if (HALF_STEP) begin
            unique case (i)
                3'd0: p = 4'b1000;
                3'd1: p = 4'b1100;
                3'd2: p = 4'b0100;
                3'd3: p = 4'b0110;
                3'd4: p = 4'b0010;
                3'd5: p = 4'b0011;
                3'd6: p = 4'b0001;
                3'd7: p = 4'b1001;
                default: p = 4'b0000;
            endcase
        end else begin
            unique case (i[1:0])
                2'd0: p = 4'b1100;
                2'd1: p = 4'b0110;
                2'd2: p = 4'b0011;
                2'd3: p = 4'b1001;
                default: p = 4'b0000;
            endcase
        end
        return p;
    endfunction

    assign edge_det      = step_clk & ~step_q;
    assign cmd.cmd_ready = ~reset_reset & (state != RUN);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign hold_inc      = hold_cnt + 32'd1;

    // Index wraps inside the active table length in both directions.
    always_comb begin
        idx_step = 3'd0;
        if (dir) idx_step = (idx + 3'd1) & IDX_MASK;
        else     idx_step = (idx - 3'd1) & IDX_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset_reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            remaining <= '0;
            hold_cnt  <= 32'd0;
            dir       <= 1'b0;
            step_q    <= 1'b0;
            coil      <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            position  <= '0;
        end else begin
            step_q  <= step_clk;
            done    <= 1'b0;
            aborted <= 1'b0;
            // A new command wins over abort; the edge of the accept cycle is dropped.
            if (accept) begin
                coil     <= phase_of(idx);
                hold_cnt <= 32'd0;
                if (cmd.cmd_steps == '0) begin
                    state <= HOLD;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    remaining <= cmd.cmd_steps;
                    dir       <= cmd.cmd_dir;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        coil <= 4'b0000;
                        busy <= 1'b0;
                    end
                    RUN: begin
                        if (cmd.abort) begin
                            state     <= HOLD;
                            busy      <= 1'b0;
                            remaining <= '0;
                            hold_cnt  <= 32'd0;
                            done      <= 1'b1;
                            aborted   <= 1'b1;
                        end else if (edge_det) begin
                            idx       <= idx_step;
                            coil      <= phase_of(idx_step);
                            remaining <= remaining - STEP_W'(1);
                            if (dir) position <= position + POS_W'(1);
                            else     position <= position - POS_W'(1);
                            if (remaining == STEP_W'(1)) begin
                                state    <= HOLD;
                                busy     <= 1'b0;
                                hold_cnt <= 32'd0;
                                done     <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (cmd.abort) begin
                            state <= IDLE;
                            coil  <= 4'b0000;
                        end else if (edge_det) begin
                            hold_cnt <= hold_inc;
                            if ((HOLD_LIM != 32'd0) && (hold_inc == HOLD_LIM)) begin
                                state <= IDLE;
                                coil  <= 4'b0000;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        coil  <= 4'b0000;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
